// File: rtl/hazard_pipe_regs.sv
// ---------------------------------------------------------------------------
// hazard_pipe_regs
//
// Hazard-relevant control fields of the 5-stage core, held in the ID/EX and
// EX/MEM pipeline registers. The registered fields feed the forwarding and
// data-hazard unit. That unit's load-use stall comes back into this block,
// where it inserts a bubble into ID/EX and freezes PC and IF/ID. The block
// also counts stall cycles and flags back-to-back stalls, which a correct
// hazard unit never produces.
//
// Parameters
//   ADDR_W        register-address width
//   STALL_CNT_W   width of the saturating stall-cycle counter
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   id_valid          ID stage holds a real instruction
//   id_reg_write      decoded RegWrite
//   id_mem_read       decoded MemRead
//   id_mem_write      decoded MemWrite
//   id_write_addr     decoded destination register
//   lw_stall          load-use stall from the hazard unit (same cycle)
//   flush             redirect: squash the ID-stage instruction
//   cnt_clr           synchronous clear of stall_cnt
//   ID_EX_*           EX-stage copies of the control fields
//   EX_MEM_*          MEM-stage copies of the control fields
//   PC_Write          PC update enable (combinational)
//   IF_ID_Write       IF/ID update enable (combinational)
//   stall_cnt         saturating count of stall cycles taken
//   stall_err         sticky flag: stall taken on two consecutive cycles
// ---------------------------------------------------------------------------
module hazard_pipe_regs #(
    parameter int ADDR_W      = 5,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   id_valid,
    input  logic                   id_reg_write,
    input  logic                   id_mem_read,
    input  logic                   id_mem_write,
    input  logic [ADDR_W-1:0]      id_write_addr,
    input  logic                   lw_stall,
    input  logic                   flush,
    input  logic                   cnt_clr,
    output logic                   ID_EX_RegWrite,
    output logic                   ID_EX_MemRead,
    output logic                   ID_EX_MemWrite,
    output logic [ADDR_W-1:0]      ID_EX_WriteAddr,
    output logic                   EX_MEM_RegWrite,
    output logic                   EX_MEM_MemRead,
    output logic [ADDR_W-1:0]      EX_MEM_WriteAddr,
    output logic                   PC_Write,
    output logic                   IF_ID_Write,
    output logic [STALL_CNT_W-1:0] stall_cnt,
    output logic                   stall_err
);

    localparam logic [STALL_CNT_W-1:0] CNT_MAX = {STALL_CNT_W{1'b1}};
    localparam logic [STALL_CNT_W-1:0] CNT_ONE = STALL_CNT_W'(1);

    // ID/EX stage
    logic              idex_rw_q,   idex_rw_d;
    logic              idex_mr_q,   idex_mr_d;
    logic              idex_mw_q,   idex_mw_d;
    logic [ADDR_W-1:0] idex_addr_q, idex_addr_d;

    // EX/MEM stage
    logic              exmem_rw_q;
    logic              exmem_mr_q;
    logic [ADDR_W-1:0] exmem_addr_q;

    // stall bookkeeping
    logic [STALL_CNT_W-1:0] cnt_q, cnt_d;
    logic                   err_q, err_d;
    logic                   prev_q, prev_d;
    logic                   stall_take;

    // A redirect overrides the stall: the stalled instruction is squashed
    // anyway, so the front end must move to the new target.
    assign stall_take  = lw_stall & ~flush;
    assign PC_Write    = ~stall_take;
    assign IF_ID_Write = ~stall_take;

    // ID/EX next state. Only a valid, unsquashed, unstalled instruction is
    // captured. Every other case loads an all-zero bubble, so garbage on
    // id_* while id_valid is low never reaches the outputs.
    always_comb begin
        idex_rw_d   = 1'b0;
        idex_mr_d   = 1'b0;
        idex_mw_d   = 1'b0;
        idex_addr_d = '0;
        if (!flush && !lw_stall && id_valid) begin
            idex_rw_d   = id_reg_write;
            idex_mr_d   = id_mem_read;
            idex_mw_d   = id_mem_write;
            idex_addr_d = id_write_addr;
        end
    end

    // stall counter, back-to-back detector
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (stall_take && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    assign prev_d = stall_take;
    assign err_d  = err_q | (stall_take & prev_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_rw_q    <= 1'b0;
            idex_mr_q    <= 1'b0;
            idex_mw_q    <= 1'b0;
            idex_addr_q  <= '0;
            exmem_rw_q   <= 1'b0;
            exmem_mr_q   <= 1'b0;
            exmem_addr_q <= '0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            prev_q       <= 1'b0;
        end else begin
            idex_rw_q    <= idex_rw_d;
            idex_mr_q    <= idex_mr_d;
            idex_mw_q    <= idex_mw_d;
            idex_addr_q  <= idex_addr_d;
            // back end never stalls: EX/MEM always takes ID/EX
            exmem_rw_q   <= idex_rw_q;
            exmem_mr_q   <= idex_mr_q;
            exmem_addr_q <= idex_addr_q;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            prev_q       <= prev_d;
        end
    end

    assign ID_EX_RegWrite   = idex_rw_q;
    assign ID_EX_MemRead    = idex_mr_q;
    assign ID_EX_MemWrite   = idex_mw_q;
    assign ID_EX_WriteAddr  = idex_addr_q;
    assign EX_MEM_RegWrite  = exmem_rw_q;
    assign EX_MEM_MemRead   = exmem_mr_q;
    assign EX_MEM_WriteAddr = exmem_addr_q;
    assign stall_cnt        = cnt_q;
    assign stall_err        = err_q;

endmodule

// File: tb/tb_hazard_pipe_regs.sv
module tb_hazard_pipe_regs;

    logic       clk;
    logic       rst_n;
    logic       id_valid, id_reg_write, id_mem_read, id_mem_write;
    logic [4:0] id_write_addr;
    logic       lw_stall, flush, cnt_clr;

    logic        ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite;
    logic [4:0]  ID_EX_WriteAddr;
    logic        EX_MEM_RegWrite, EX_MEM_MemRead;
    logic [4:0]  EX_MEM_WriteAddr;
    logic        PC_Write, IF_ID_Write;
    logic [15:0] stall_cnt;
    logic        stall_err;

    logic        b_idex_rw, b_idex_mr, b_idex_mw;
    logic [4:0]  b_idex_addr;
    logic        b_exmem_rw, b_exmem_mr;
    logic [4:0]  b_exmem_addr;
    logic        b_pc_write, b_ifid_write;
    logic [1:0]  b_stall_cnt;
    logic        b_stall_err;

    hazard_pipe_regs #(.ADDR_W(5), .STALL_CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_write_addr(id_write_addr), .lw_stall(lw_stall),
        .flush(flush), .cnt_clr(cnt_clr),
        .ID_EX_RegWrite(ID_EX_RegWrite), .ID_EX_MemRead(ID_EX_MemRead),
        .ID_EX_MemWrite(ID_EX_MemWrite), .ID_EX_WriteAddr(ID_EX_WriteAddr),
        .EX_MEM_RegWrite(EX_MEM_RegWrite), .EX_MEM_MemRead(EX_MEM_MemRead),
        .EX_MEM_WriteAddr(EX_MEM_WriteAddr),
        .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write),
        .stall_cnt(stall_cnt), .stall_err(stall_err)
    );

    hazard_pipe_regs #(.ADDR_W(5), .STALL_CNT_W(2)) dut_narrow (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_write_addr(id_write_addr), .lw_stall(lw_stall),
        .flush(flush), .cnt_clr(cnt_clr),
        .ID_EX_RegWrite(b_idex_rw), .ID_EX_MemRead(b_idex_mr),
        .ID_EX_MemWrite(b_idex_mw), .ID_EX_WriteAddr(b_idex_addr),
        .EX_MEM_RegWrite(b_exmem_rw), .EX_MEM_MemRead(b_exmem_mr),
        .EX_MEM_WriteAddr(b_exmem_addr),
        .PC_Write(b_pc_write), .IF_ID_Write(b_ifid_write),
        .stall_cnt(b_stall_cnt), .stall_err(b_stall_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic       rw;
        logic       mr;
        logic       mw;
        logic [4:0] addr;
    } stage_t;

    stage_t q_idex[$];
    stage_t q_exmem[$];

    int          n_total;
    int          n_bad;
    logic [15:0] m_cnt16;
    logic [1:0]  m_cnt2;
    logic        m_err;
    logic        m_prev;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q_idex.delete();
        q_exmem.delete();
        q_exmem.push_back('0);
        m_cnt16 = '0;
        m_cnt2  = '0;
        m_err   = 1'b0;
        m_prev  = 1'b0;
    endtask

    task automatic drive_idle();
        id_valid      = 1'b0;
        id_reg_write  = 1'b0;
        id_mem_read   = 1'b0;
        id_mem_write  = 1'b0;
        id_write_addr = '0;
        lw_stall      = 1'b0;
        flush         = 1'b0;
        cnt_clr       = 1'b0;
    endtask

    // one clock: drive at negedge, check freeze outputs, push expectation,
    // then compare registered outputs just after the posedge
    task automatic cyc(input logic v, input logic rw, input logic mr, input logic mw,
                       input logic [4:0] a, input logic lws, input logic fl, input logic clr);
        stage_t e;
        stage_t got;
        stage_t e_mem;
        logic   take;
        @(negedge clk);
        id_valid      = v;
        id_reg_write  = rw;
        id_mem_read   = mr;
        id_mem_write  = mw;
        id_write_addr = a;
        lw_stall      = lws;
        flush         = fl;
        cnt_clr       = clr;
        #1;
        check("pc_write",   {31'd0, PC_Write},    {31'd0, ~lws | fl});
        check("ifid_write", {31'd0, IF_ID_Write}, {31'd0, ~lws | fl});
        e = '0;
        if (!fl && !lws && v) e = '{rw: rw, mr: mr, mw: mw, addr: a};
        q_idex.push_back(e);
        take   = lws & ~fl;
        m_err  = m_err | (take & m_prev);
        m_prev = take;
        if (clr) begin
            m_cnt16 = '0;
            m_cnt2  = '0;
        end else if (take) begin
            if (m_cnt16 != 16'hffff) m_cnt16 = m_cnt16 + 16'd1;
            if (m_cnt2 != 2'd3)      m_cnt2  = m_cnt2 + 2'd1;
        end
        @(posedge clk);
        #1;
        e     = q_idex.pop_front();
        e_mem = q_exmem.pop_front();
        got   = '{rw: ID_EX_RegWrite, mr: ID_EX_MemRead, mw: ID_EX_MemWrite, addr: ID_EX_WriteAddr};
        check("id_ex", {24'd0, got}, {24'd0, e});
        check("ex_mem", {25'd0, EX_MEM_RegWrite, EX_MEM_MemRead, EX_MEM_WriteAddr},
              {25'd0, e_mem.rw, e_mem.mr, e_mem.addr});
        q_exmem.push_back(e);
        check("stall_cnt16", {16'd0, stall_cnt}, {16'd0, m_cnt16});
        check("stall_cnt2",  {30'd0, b_stall_cnt}, {30'd0, m_cnt2});
        check("stall_err",   {31'd0, stall_err}, {31'd0, m_err});
        check("stall_err2",  {31'd0, b_stall_err}, {31'd0, m_err});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // asynchronous reset mid-cycle with every input high
    task automatic reset_async();
        #1;
        id_valid = 1'b1; id_reg_write = 1'b1; id_mem_read = 1'b1; id_mem_write = 1'b1;
        id_write_addr = 5'h1f; lw_stall = 1'b1; flush = 1'b1; cnt_clr = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_id_ex", {28'd0, ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, |ID_EX_WriteAddr}, 32'd0);
        check("rst_ex_mem", {29'd0, EX_MEM_RegWrite, EX_MEM_MemRead, |EX_MEM_WriteAddr}, 32'd0);
        check("rst_cnt", {15'd0, stall_cnt, b_stall_cnt}, 32'd0);
        check("rst_err", {30'd0, stall_err, b_stall_err}, 32'd0);
        check("rst_pc_write", {31'd0, PC_Write}, 32'd1);
        drive_idle();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        drive_idle();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check("por_id_ex", {27'd0, ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_WriteAddr}, 32'd0);
        check("por_cnt", {16'd0, stall_cnt}, 32'd0);
        rst_n = 1'b1;

        // capture and two-stage latency of a plain ALU write
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 5'd7, 1'b0, 1'b0, 1'b0);
        check("lat_idex_addr", {27'd0, ID_EX_WriteAddr}, 32'd7);
        cyc(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom), 1'b0, 1'b0, 1'b0);
        check("lat_exmem_addr", {27'd0, EX_MEM_WriteAddr}, 32'd7);
        idle(1);

        // load in EX, one-cycle load-use stall, then the instruction re-issues
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
        check("lu_cnt", {16'd0, stall_cnt}, 32'd1);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0);

        // flush and stall together: bubble, no freeze, no count
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 5'd12, 1'b1, 1'b1, 1'b0);
        idle(2);

        // id_valid low with random id_* fields
        for (int i = 0; i < 4; i++)
            cyc(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom), 1'b0, 1'b0, 1'b0);

        // reset taken right after a stall clears the back-to-back history
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 5'd15, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0);
        reset_async();
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0);
        idle(2);

        // saturation on the narrow counter, then clear beating an increment
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0, 5'd1, 1'b1, 1'b0, 1'b0);
            idle(1);
        end
        check("sat_cnt2", {30'd0, b_stall_cnt}, 32'd3);
        check("nosat_cnt16", {16'd0, stall_cnt}, 32'd4);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 5'd1, 1'b1, 1'b0, 1'b1);
        check("clr_wins", {16'd0, stall_cnt}, 32'd0);
        idle(1);

        // back-to-back stall sets the sticky error
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 5'd2, 1'b1, 1'b0, 1'b0);
        check("err_first_edge", {31'd0, stall_err}, 32'd0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 5'd2, 1'b1, 1'b0, 1'b0);
        check("err_second_edge", {31'd0, stall_err}, 32'd1);
        idle(10);
        check("err_sticky", {31'd0, stall_err}, 32'd1);

        // random traffic
        for (int i = 0; i < 40; i++)
            cyc(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom),
                ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0), ($urandom_range(0, 9) == 0));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
